// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a circular byte FIFO feeding a
// start/data/stop serializer. All outputs come straight from registers.
module uart_tx_fifo #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd104,
    parameter int unsigned LGFIFO          = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stb,
    input  logic [7:0]        i_data,
    output logic              o_busy,
    output logic [LGFIFO:0]   o_fill,
    output logic              o_idle,
    output logic              o_uart_tx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam int unsigned       DEPTH       = 32'd1 << LGFIFO;
    localparam logic [LGFIFO:0]   FILL_FULL_C = (LGFIFO + 1)'(DEPTH);
    localparam logic [LGFIFO:0]   FILL_ONE_C  = (LGFIFO + 1)'(32'd1);
    localparam logic [LGFIFO:0]   FILL_ZERO_C = (LGFIFO + 1)'(32'd0);
    localparam logic [LGFIFO-1:0] PTR_ONE_C   = LGFIFO'(32'd1);
    localparam logic [LGFIFO-1:0] PTR_ZERO_C  = LGFIFO'(32'd0);
    localparam logic [23:0]       BAUD_LAST_C = CLOCKS_PER_BAUD - 24'd1;

    // FIFO storage and bookkeeping
    logic [7:0]        mem_q [DEPTH];
    logic [LGFIFO-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGFIFO-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGFIFO:0]   fill_q, fill_d;
    logic              busy_q, busy_d;
    logic              idle_q, idle_d;

    // Serializer state
    state_t            state_q, state_d;
    logic [23:0]       baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    logic              push_s;
    logic              pop_s;
    logic [7:0]        head_s;

    // A write is taken only when the registered full flag was low before the edge
    assign push_s = i_stb && !busy_q;
    assign head_s = mem_q[rd_ptr_q];

    // Serializer next-state: baud countdown, bit sequencing and FIFO pops
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (fill_q != FILL_ZERO_C) begin
                    pop_s   = 1'b1;
                    shift_d = head_s;
                    tx_d    = 1'b0;
                    baud_d  = BAUD_LAST_C;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_q == 24'd0) begin
                    tx_d      = shift_q[0];
                    baud_d    = BAUD_LAST_C;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q - 24'd1;
                end
            end
            ST_DATA: begin
                if (baud_q == 24'd0) begin
                    baud_d = BAUD_LAST_C;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        // shift_q[0] is on the line; expose the next bit
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 24'd1;
                end
            end
            ST_STOP: begin
                if (baud_q == 24'd0) begin
                    if (fill_q != FILL_ZERO_C) begin
                        // chain straight into the next start bit, no idle gap
                        pop_s   = 1'b1;
                        shift_d = head_s;
                        tx_d    = 1'b0;
                        baud_d  = BAUD_LAST_C;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 24'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO next-state: pointer advance, fill count and registered status flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   fill_d = fill_q + FILL_ONE_C;
            2'b01:   fill_d = fill_q - FILL_ONE_C;
            default: fill_d = fill_q;
        endcase
        busy_d = (fill_d == FILL_FULL_C);
        idle_d = (fill_d == FILL_ZERO_C) && (state_d == ST_IDLE);
    end

    // FIFO data array; no reset needed since pointers gate every read
    always_ff @(posedge i_clk) begin
        if (push_s && !i_reset) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // State registers with synchronous reset; reset aborts any frame in flight
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q  <= PTR_ZERO_C;
            rd_ptr_q  <= PTR_ZERO_C;
            fill_q    <= FILL_ZERO_C;
            busy_q    <= 1'b0;
            idle_q    <= 1'b1;
            state_q   <= ST_IDLE;
            baud_q    <= 24'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            busy_q    <= busy_d;
            idle_q    <= idle_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_fill    = fill_q;
    assign o_idle    = idle_q;
    assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: two instances (16-deep and 4-deep),
// stimulus pushes expected bytes, UART monitors decode the lines and compare.
module tb_uart_tx_fifo;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic       rst_a = 1'b1, stb_a = 1'b0;
    logic [7:0] data_a = 8'd0;
    logic       busy_a, idle_a, tx_a;
    logic [4:0] fill_a;

    logic       rst_b = 1'b1, stb_b = 1'b0;
    logic [7:0] data_b = 8'd0;
    logic       busy_b, idle_b, tx_b;
    logic [2:0] fill_b;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         rcnt_a = 0, rcnt_b = 0;
    int         last_start_a = 0;
    bit         gap_en_a = 1'b0, have_prev_a = 1'b0;
    int         prev_start_a = 0;

    uart_tx_fifo #(.CLOCKS_PER_BAUD(24'd8), .LGFIFO(4)) dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_stb(stb_a), .i_data(data_a),
        .o_busy(busy_a), .o_fill(fill_a), .o_idle(idle_a), .o_uart_tx(tx_a)
    );

    uart_tx_fifo #(.CLOCKS_PER_BAUD(24'd8), .LGFIFO(2)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_stb(stb_b), .i_data(data_b),
        .o_busy(busy_b), .o_fill(fill_b), .o_idle(idle_b), .o_uart_tx(tx_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_a) rcnt_a <= rcnt_a + 1;
        if (rst_b) rcnt_b <= rcnt_b + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic line(input int sel);
        return (sel == 0) ? tx_a : tx_b;
    endfunction

    // Decode frames on one line and compare against that line's queue
    task automatic monitor(input int sel);
        logic [7:0] b;
        logic       st_bit, sp_bit;
        int         start_cyc, rc0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (line(sel) === 1'b0) begin
                start_cyc = cyc;
                rc0 = (sel == 0) ? rcnt_a : rcnt_b;
                repeat (CPB / 2) @(negedge clk);
                st_bit = line(sel);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = line(sel);
                end
                repeat (CPB) @(negedge clk);
                sp_bit = line(sel);
                if (rc0 == ((sel == 0) ? rcnt_a : rcnt_b)) begin
                    check((sel == 0) ? "start_bit_a" : "start_bit_b", {31'd0, st_bit}, 32'd0);
                    check((sel == 0) ? "stop_bit_a" : "stop_bit_b", {31'd0, sp_bit}, 32'd1);
                    if (sel == 0) begin
                        last_start_a = start_cyc;
                        if (gap_en_a) begin
                            if (have_prev_a) check("frame_gap_a", start_cyc - prev_start_a, 10 * CPB);
                            prev_start_a = start_cyc;
                            have_prev_a = 1'b1;
                        end
                    end
                    if (((sel == 0) ? exp_a.size() : exp_b.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame_%0d: got %02h required no frame", sel, b);
                    end else begin
                        e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
                        check((sel == 0) ? "byte_a" : "byte_b", {24'd0, b}, {24'd0, e});
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_idle(input int sel, input int budget);
        int n;
        n = 0;
        while (((sel == 0) ? idle_a : idle_b) !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check((sel == 0) ? "idle_wait_a" : "idle_wait_b",
              {31'd0, (sel == 0) ? idle_a : idle_b}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int    c0;
        int    peak;
        string msg;
        msg = "Hello, World! \r\n";

        // 1: reset then 50 idle cycles
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;
        check("rst_b_busy", {31'd0, busy_b}, 32'd0);
        check("rst_b_fill", {29'd0, fill_b}, 32'd0);
        check("rst_b_idle", {31'd0, idle_b}, 32'd1);
        check("rst_b_tx", {31'd0, tx_b}, 32'd1);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_tx", {31'd0, tx_a}, 32'd1);
            check("idle_busy", {31'd0, busy_a}, 32'd0);
            check("idle_fill", {27'd0, fill_a}, 32'd0);
            check("idle_idle", {31'd0, idle_a}, 32'd1);
        end

        // 2: single 'H' frame timing
        data_a = 8'h48; stb_a = 1'b1;
        exp_a.push_back(8'h48);
        tick();
        c0 = cyc;
        stb_a = 1'b0;
        check("e0_fill", {27'd0, fill_a}, 32'd1);
        check("e0_idle", {31'd0, idle_a}, 32'd0);
        check("e0_tx", {31'd0, tx_a}, 32'd1);
        tick();
        check("e1_tx_start", {31'd0, tx_a}, 32'd0);
        repeat (79) tick();
        check("e80_idle", {31'd0, idle_a}, 32'd0);
        tick();
        check("e81_idle", {31'd0, idle_a}, 32'd1);
        check("h_start_cycle", last_start_a, c0 + 1);
        check("h_received", exp_a.size(), 32'd0);

        // 3: 16 back-to-back bytes, contiguous frames
        gap_en_a = 1'b1; have_prev_a = 1'b0;
        peak = 0;
        for (int i = 0; i < 16; i++) begin
            data_a = msg[i]; stb_a = 1'b1;
            exp_a.push_back(msg[i]);
            tick();
            if (int'(fill_a) > peak) peak = int'(fill_a);
        end
        stb_a = 1'b0;
        check("burst_peak_15_16", {31'd0, (peak == 15 || peak == 16)}, 32'd1);
        wait_idle(0, 16 * 10 * CPB + 100);
        gap_en_a = 1'b0;

        // 5: reset mid-DATA of the 2nd of 3 queued bytes
        for (int i = 0; i < 3; i++) begin
            data_a = 8'h31 + 8'(i); stb_a = 1'b1;
            exp_a.push_back(8'h31 + 8'(i));
            tick();
        end
        stb_a = 1'b0;
        repeat (110) tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        void'(exp_a.pop_back());
        void'(exp_a.pop_back());
        check("abort_tx", {31'd0, tx_a}, 32'd1);
        check("abort_fill", {27'd0, fill_a}, 32'd0);
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        check("abort_idle", {31'd0, idle_a}, 32'd1);
        for (int i = 0; i < 200; i++) begin
            tick();
            check("post_abort_tx", {31'd0, tx_a}, 32'd1);
        end
        data_a = 8'hA5; stb_a = 1'b1;
        exp_a.push_back(8'hA5);
        tick();
        stb_a = 1'b0;
        wait_idle(0, 10 * CPB + 20);

        // 4: continuous i_stb into a 4-deep FIFO
        for (int k = 0; k <= 170; k++) begin
            data_b = 8'(k); stb_b = 1'b1;
            if (k <= 4 || k == 82 || k == 162) exp_b.push_back(8'(k));
            tick();
            if (k == 4 || k == 80 || k == 82 || k == 162) begin
                check("cont_busy_hi", {31'd0, busy_b}, 32'd1);
                check("cont_fill_4", {29'd0, fill_b}, 32'd4);
            end
            if (k == 81 || k == 161) begin
                check("cont_busy_lo", {31'd0, busy_b}, 32'd0);
                check("cont_fill_3", {29'd0, fill_b}, 32'd3);
            end
        end
        stb_b = 1'b0;
        wait_idle(1, 8 * 10 * CPB);

        // 6: write colliding with a pop while full is rejected
        for (int k = 0; k <= 82; k++) begin
            stb_b = (k <= 4 || k == 81 || k == 82);
            data_b = (k <= 4) ? 8'h10 + 8'(k) : ((k == 81) ? 8'hEE : 8'h77);
            if (k <= 4 || k == 82) exp_b.push_back(data_b);
            tick();
            if (k == 4 || k == 82) begin
                check("col_fill_4", {29'd0, fill_b}, 32'd4);
                check("col_busy_hi", {31'd0, busy_b}, 32'd1);
            end
            if (k == 81) begin
                check("col_fill_3", {29'd0, fill_b}, 32'd3);
                check("col_busy_lo", {31'd0, busy_b}, 32'd0);
            end
        end
        stb_b = 1'b0;
        wait_idle(1, 7 * 10 * CPB);

        repeat (20) tick();
        check("queue_a_empty", exp_a.size(), 32'd0);
        check("queue_b_empty", exp_b.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered 8N1 UART transmitter that is the serial back end of the message generators. It accepts bytes on a strobe/busy handshake, queues them in a FIFO of 2^LGFIFO entries, and serializes them onto o_uart_tx. A full 16-byte message can be written back-to-back without waiting on the line rate.

Parameters:
CLOCKS_PER_BAUD, 24'd104, i_clk cycles per UART bit; legal range 2 to 2^24-1.
LGFIFO, 4, log2 of FIFO depth (default 16 entries); legal range 1 to 8.

Ports:
i_clk  input  1  system clock; all logic on rising edge.
i_reset  input  1  synchronous, active-high reset.
i_stb  input  1  write request; the byte is accepted on an edge where i_stb && !o_busy.
i_data  input  8  byte to queue; sampled on the accepting edge.
o_busy  output  1  FIFO full; writes are ignored while high.
o_fill  output  LGFIFO+1  number of queued bytes not yet popped by the serializer.
o_idle  output  1  high when the FIFO is empty and the serializer is in IDLE.
o_uart_tx  output  1  serial line; idles high.

Behaviour:
- Reset (sampled on any edge, including mid-frame):
  - o_uart_tx=1, o_busy=0, o_fill=0, o_idle=1.
  - FIFO pointers cleared, state goes to IDLE, baud counter cleared.
  - An in-flight frame is aborted and the line is high after that edge. No partial resume.
- FIFO:
  - Circular buffer with LGFIFO-bit read/write pointers and an (LGFIFO+1)-bit fill count.
  - Pointers wrap modulo 2^LGFIFO.
  - Write when o_busy=1 is dropped: no overwrite, no count change.
  - o_busy is registered and equals (fill == 2^LGFIFO) after each edge.
  - Simultaneous accepted write and pop: fill unchanged.
  - Pop while full frees a slot; o_busy drops on the same edge that updates fill.
  - Write into an empty FIFO is not bypassed; it goes through the buffer.
- Serializer states:
  - IDLE: o_uart_tx=1. If fill!=0, pop the head byte into the shift register, drive o_uart_tx=0, load baud counter with CLOCKS_PER_BAUD-1, go to START.
  - START: hold 0 for CLOCKS_PER_BAUD cycles, then drive bit0 and go to DATA.
  - DATA: 8 bits LSB first, each held CLOCKS_PER_BAUD cycles, with a 3-bit bit index. After bit7 expires, drive 1 and go to STOP.
  - STOP: hold 1 for CLOCKS_PER_BAUD cycles. On expiry:
    - if fill!=0, pop the next byte and start a new start bit on that same edge, giving no idle gap between frames;
    - otherwise go to IDLE.
- Timing:
  - A byte accepted on edge E0 into an empty, idle block appears in o_fill after E0.
  - The start bit begins after edge E0+1.
  - A frame is exactly 10*CLOCKS_PER_BAUD cycles; back-to-back frames are contiguous.
- o_uart_tx is driven from a register (glitch-free). No combinational path from i_stb to any output.
- o_idle is registered: it is high only when fill==0 and state==IDLE after the edge.
- Baud counter width is 24 bits; it counts down and the bit ends when it reaches 0.

Test Plan:
1. Reset, then idle 50 cycles, CLOCKS_PER_BAUD=8 -> o_uart_tx=1, o_busy=0, o_fill=0, o_idle=1 throughout.
2. Single write of 8'h48 ('H'), CLOCKS_PER_BAUD=8 -> start bit low from E0+1 for 8 cycles, then bits 0,0,0,1,0,0,1,0 each 8 cycles, stop high 8 cycles, o_idle=1 at cycle 81 after E0.
3. Write 16 bytes "Hello, World! \r\n" on 16 consecutive cycles, LGFIFO=4 -> o_fill peaks at 15 or 16. The UART monitor decodes all 16 bytes in order with frames exactly 80 cycles apart and no gap.
4. Hold i_stb=1 continuously with incrementing data, LGFIFO=2 -> o_busy asserts when fill=4. Bytes offered while busy are not transmitted. o_busy drops after each pop. Decoded stream has no duplicates or corruption.
5. Assert i_reset for 1 cycle mid DATA of the 2nd of 3 queued bytes -> line high the cycle after, o_fill=0, no further frames. A new write of 8'hA5 after reset transmits cleanly.
6. Write on the same edge the serializer pops, with fill=4 and LGFIFO=2 -> write rejected (o_busy was 1), fill becomes 3. Next-cycle write accepted, fill becomes 4.
